mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port of the multicycle LEGv8 core between the instruction-fetch
//  requester (driven in the FSM fetch state) and the data requester (driven in LDUR/STUR states).
//  Registered arbitration with a single outstanding transaction, variable memory latency, a
//  no-ack timeout and an anti-starvation guard for fetch. Sits between the control FSM and memory.
// PARAMETERS
//  ADDR_W           64   address width
//  DATA_W           64   data width (fetch data carries INSTRUCTION)
//  TIMEOUT_CYCLES   16   max cycles in BUSY waiting for MEM_ACK (1..255)
//  MAX_DATA_STREAK  4    consecutive data grants with fetch waiting before fetch wins (1..15)
// PORTS
//  CLOCK       in   1       rising-edge clock
//  RESET       in   1       asynchronous, active-high reset
//  IF_REQ      in   1       fetch request; hold with IF_ADDR stable until IF_DONE
//  IF_ADDR     in   ADDR_W  fetch address
//  IF_RDATA    out  DATA_W  fetched word, valid while IF_DONE=1
//  IF_DONE     out  1       one-cycle completion pulse for fetch
//  D_REQ       in   1       data request; hold with D_ADDR/D_WE/D_WDATA stable until D_DONE
//  D_WE        in   1       1=store (STUR), 0=load (LDUR)
//  D_ADDR      in   ADDR_W  data address
//  D_WDATA     in   DATA_W  store data
//  D_RDATA     out  DATA_W  load data, valid while D_DONE=1 and D_WE was 0
//  D_DONE      out  1       one-cycle completion pulse for data
//  ERR         out  1       qualifies a DONE pulse: transaction timed out
//  MEM_REQ     out  1       memory request, held until MEM_ACK or timeout
//  MEM_WE      out  1       memory write enable
//  MEM_ADDR    out  ADDR_W  memory address
//  MEM_WDATA   out  DATA_W  memory write data
//  MEM_RDATA   in   DATA_W  memory read data, valid with MEM_ACK
//  MEM_ACK     in   1       memory completion, one cycle
//  BUSY        out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - All outputs registered. RESET (async): state=IDLE, every output 0, streak/timeout counters 0.
//  - States: IDLE, BUSY_IF, BUSY_D, DONE_IF, DONE_D.
//  - IDLE: requests sampled ONLY here. Winner -> BUSY_x at next edge; latch addr/we/wdata onto
//    MEM_*; MEM_REQ=1; MEM_WE=D_WE for data, 0 for fetch; timeout counter=0.
//  - Priority: D wins over IF, except when both request and streak==MAX_DATA_STREAK -> IF wins.
//    streak increments on a data grant while IF_REQ=1 (saturating), clears on any IF grant.
//    Data grant with IF_REQ=0 leaves streak unchanged.
//  - BUSY_x: MEM_ACK=1 at an edge -> DONE_x; x_RDATA<=MEM_RDATA (fetch or load only; stores leave
//    D_RDATA unchanged); MEM_REQ,MEM_WE<=0; x_DONE=1; ERR=0. Else counter++; when counter reaches
//    TIMEOUT_CYCLES-1 without ack -> DONE_x with ERR=1, x_RDATA<=0, MEM_REQ<=0.
//  - DONE_x: lasts exactly one cycle, then IDLE; x_DONE, ERR cleared on leaving.
//  - Latency (ack k cycles after MEM_REQ rises, k>=1): REQ seen at edge t -> MEM_REQ high from t,
//    DONE high from edge t+k for one cycle; next grant earliest at edge t+k+2.
//  - MEM_ACK in IDLE/DONE_x (late ack after timeout) is ignored; no DONE, no data change.
//  - Request dropped mid-transaction: transaction still completes; DONE still pulses.
//  - RESET asserted mid-transaction: MEM_REQ drops immediately, no DONE pulse is produced.
//  - MEM_ADDR/MEM_WDATA hold their last values when MEM_REQ=0.
// TESTING
//  1 IF_REQ, IF_ADDR=0x40, ack after 2 cycles with MEM_RDATA=0x8B020020 -> IF_DONE 1 cycle, RDATA match, MEM_WE=0.
//  2 IF_REQ and D_REQ (D_WE=1, D_ADDR=0x100, D_WDATA=0xDEAD) same cycle -> data granted first with MEM_WE=1;
//    fetch granted in the IDLE cycle after D_DONE.
//  3 D_REQ held continuously with IF_REQ=1, MAX_DATA_STREAK=4 -> exactly 4 data grants, then 1 fetch grant.
//  4 No MEM_ACK for 16 cycles -> D_DONE with ERR=1, D_RDATA=0, MEM_REQ low; later stray MEM_ACK ignored.
//  5 RESET pulsed while in BUSY_IF -> MEM_REQ, BUSY low asynchronously, no IF_DONE; new IF_REQ completes.
//  6 Load (D_WE=0, addr 0x8) then store -> D_RDATA holds load value through the store's D_DONE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single unified memory port of the multicycle
// LEGv8 core between the instruction-fetch requester and the data (LDUR/STUR)
// requester. One transaction is outstanding at a time. Memory latency is
// variable, a missing acknowledge is bounded by a timeout, and a streak
// counter keeps a steady stream of data accesses from starving fetch.
module mem_port_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    output logic [DATA_W-1:0] IF_RDATA,
    output logic              IF_DONE,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_DONE,
    output logic              ERR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic              MEM_ACK,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_D  = 3'd2,
        ST_DONE_IF = 3'd3,
        ST_DONE_D  = 3'd4
    } state_t;

    // Last BUSY cycle before giving up, and the streak value at which fetch wins.
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    state_t      state_r;
    logic [7:0]  to_cnt_r;
    logic [3:0]  streak_r;
    logic        grant_if_s;
    logic        grant_d_s;
    logic        timeout_s;

    // Pick the winner of an IDLE-state grant: data first unless fetch has waited out a full streak.
    always_comb begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (D_REQ && !(IF_REQ && (streak_r == STREAK_MAX))) begin
            grant_d_s = 1'b1;
        end else if (IF_REQ) begin
            grant_if_s = 1'b1;
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // Flag the BUSY cycle on which a missing acknowledge ends the transaction.
    always_comb begin
        timeout_s = 1'b0;
        if (to_cnt_r == TO_LAST) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            to_cnt_r  <= 8'd0;
            streak_r  <= 4'd0;
            IF_RDATA  <= {DATA_W{1'b0}};
            IF_DONE   <= 1'b0;
            D_RDATA   <= {DATA_W{1'b0}};
            D_DONE    <= 1'b0;
            ERR       <= 1'b0;
            MEM_REQ   <= 1'b0;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= {ADDR_W{1'b0}};
            MEM_WDATA <= {DATA_W{1'b0}};
            BUSY      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_d_s) begin
                        state_r   <= ST_BUSY_D;
                        MEM_REQ   <= 1'b1;
                        MEM_WE    <= D_WE;
                        MEM_ADDR  <= D_ADDR;
                        MEM_WDATA <= D_WDATA;
                        to_cnt_r  <= 8'd0;
                        BUSY      <= 1'b1;
                        // Only count data wins that actually kept fetch waiting.
                        if (IF_REQ && (streak_r != STREAK_MAX)) begin
                            streak_r <= streak_r + 4'd1;
                        end else begin
                            streak_r <= streak_r;
                        end
                    end else if (grant_if_s) begin
                        state_r  <= ST_BUSY_IF;
                        MEM_REQ  <= 1'b1;
                        MEM_WE   <= 1'b0;
                        MEM_ADDR <= IF_ADDR;
                        to_cnt_r <= 8'd0;
                        streak_r <= 4'd0;
                        BUSY     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY_IF, ST_BUSY_D: begin
                    if (MEM_ACK || timeout_s) begin
                        // An acknowledge on the last allowed cycle still counts as success.
                        MEM_REQ <= 1'b0;
                        MEM_WE  <= 1'b0;
                        ERR     <= ~MEM_ACK;
                        if (state_r == ST_BUSY_IF) begin
                            state_r  <= ST_DONE_IF;
                            IF_DONE  <= 1'b1;
                            IF_RDATA <= MEM_ACK ? MEM_RDATA : {DATA_W{1'b0}};
                        end else begin
                            state_r <= ST_DONE_D;
                            D_DONE  <= 1'b1;
                            if (!MEM_ACK) begin
                                D_RDATA <= {DATA_W{1'b0}};
                            end else if (!MEM_WE) begin
                                D_RDATA <= MEM_RDATA;
                            end else begin
                                D_RDATA <= D_RDATA;
                            end
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + 8'd1;
                    end
                end
                ST_DONE_IF, ST_DONE_D: begin
                    state_r <= ST_IDLE;
                    IF_DONE <= 1'b0;
                    D_DONE  <= 1'b0;
                    ERR     <= 1'b0;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    IF_DONE <= 1'b0;
                    D_DONE  <= 1'b0;
                    ERR     <= 1'b0;
                    MEM_REQ <= 1'b0;
                    MEM_WE  <= 1'b0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: vector table, directed multi-cycle
// sequences and a randomized transaction-level scoreboard.
module tb_mem_port_arbiter;

    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int TO   = 16;
    localparam int MAXS = 4;

    logic          CLOCK = 1'b0;
    logic          RESET;
    logic          IF_REQ;
    logic [AW-1:0] IF_ADDR;
    logic [DW-1:0] IF_RDATA;
    logic          IF_DONE;
    logic          D_REQ;
    logic          D_WE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic [DW-1:0] D_RDATA;
    logic          D_DONE;
    logic          ERR;
    logic          MEM_REQ;
    logic          MEM_WE;
    logic [AW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_ACK;
    logic          BUSY;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .MAX_DATA_STREAK(MAXS)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_RDATA(IF_RDATA), .IF_DONE(IF_DONE),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_RDATA(D_RDATA), .D_DONE(D_DONE), .ERR(ERR),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .BUSY(BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        if_req;
        logic        d_req;
        logic        d_we;
        logic [63:0] if_addr;
        logic [63:0] d_addr;
        logic [63:0] d_wdata;
        int          lat;
        logic [63:0] mem_rdata;
        logic        exp_d_win;
        logic        exp_we;
        logic [63:0] exp_addr;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic do_reset();
        IF_REQ = 1'b0; IF_ADDR = 64'd0;
        D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = 64'd0; D_WDATA = 64'd0;
        MEM_ACK = 1'b0; MEM_RDATA = 64'd0;
        RESET = 1'b1;
        @(posedge CLOCK); #1;
        RESET = 1'b0;
        @(posedge CLOCK); #1;
    endtask

    // Wait (bounded) for MEM_REQ to rise; returns just after the granting edge.
    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6 && !ok; i++) begin
            @(posedge CLOCK); #1;
            if (MEM_REQ) ok = 1'b1;
        end
        check("grant_seen", 64'(ok), 64'd1);
    endtask

    // Memory responder: ack sampled k edges after the grant edge, or never.
    // Returns just after the edge where DONE is expected.
    task automatic serve(input int k, input bit no_ack, input logic [63:0] rdata);
        int cycles;
        cycles = no_ack ? TO : k;
        for (int i = 1; i < cycles; i++) begin
            @(posedge CLOCK); #1;
            check("early_done", 64'(IF_DONE | D_DONE), 64'd0);
        end
        if (!no_ack) begin
            MEM_ACK = 1'b1;
            MEM_RDATA = rdata;
        end
        @(posedge CLOCK); #1;
        MEM_ACK = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        bit          got_if;
        bit          pend_if, pend_d, exp_d, no_ack;
        int          streak, k;
        logic [63:0] m_if_rd, m_d_rd, rd, m_if_addr, m_d_addr, m_d_wdata;
        logic        m_d_we;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h40, 64'h0, 64'h0, 2, 64'h8B020020,
                    1'b0, 1'b0, 64'h40, 64'h8B020020};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h8, 64'h0, 1, 64'h1122334455667788,
                    1'b1, 1'b0, 64'h8, 64'h1122334455667788};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 64'h0, 64'h100, 64'hDEAD, 3, 64'hFFFF,
                    1'b1, 1'b1, 64'h100, 64'h1122334455667788};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 64'h80, 64'h200, 64'h0, 4, 64'hA5A5,
                    1'b1, 1'b0, 64'h200, 64'hA5A5};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0, 1, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h0, 64'h18, 64'h0, 16, 64'h0123456789ABCDEF,
                    1'b1, 1'b0, 64'h18, 64'h0123456789ABCDEF};

        // Reset state while reset is held
        IF_REQ = 1'b0; IF_ADDR = 64'd0; D_REQ = 1'b0; D_WE = 1'b0;
        D_ADDR = 64'd0; D_WDATA = 64'd0; MEM_ACK = 1'b0; MEM_RDATA = 64'd0;
        RESET = 1'b1;
        #12;
        check("rst_busy", 64'(BUSY), 64'd0);
        check("rst_mem_req", 64'(MEM_REQ), 64'd0);
        check("rst_done", 64'({IF_DONE, D_DONE, ERR, MEM_WE}), 64'd0);
        check("rst_if_rdata", IF_RDATA, 64'd0);
        check("rst_d_rdata", D_RDATA, 64'd0);
        check("rst_mem_addr", MEM_ADDR, 64'd0);
        do_reset();

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            IF_REQ = vecs[v].if_req; IF_ADDR = vecs[v].if_addr;
            D_REQ = vecs[v].d_req; D_WE = vecs[v].d_we;
            D_ADDR = vecs[v].d_addr; D_WDATA = vecs[v].d_wdata;
            wait_grant(ok);
            check($sformatf("vec%0d_mem_addr", v), MEM_ADDR, vecs[v].exp_addr);
            check($sformatf("vec%0d_mem_we", v), 64'(MEM_WE), 64'(vecs[v].exp_we));
            if (vecs[v].exp_we) check($sformatf("vec%0d_mem_wdata", v), MEM_WDATA, vecs[v].d_wdata);
            check($sformatf("vec%0d_busy", v), 64'(BUSY), 64'd1);
            serve(vecs[v].lat, 1'b0, vecs[v].mem_rdata);
            check($sformatf("vec%0d_if_done", v), 64'(IF_DONE), 64'(!vecs[v].exp_d_win));
            check($sformatf("vec%0d_d_done", v), 64'(D_DONE), 64'(vecs[v].exp_d_win));
            check($sformatf("vec%0d_err", v), 64'(ERR), 64'd0);
            check($sformatf("vec%0d_mem_req_low", v), 64'(MEM_REQ), 64'd0);
            check($sformatf("vec%0d_rdata", v), vecs[v].exp_d_win ? D_RDATA : IF_RDATA, vecs[v].exp_rdata);
            IF_REQ = 1'b0; D_REQ = 1'b0;
            @(posedge CLOCK); #1;
            check($sformatf("vec%0d_done_one_cycle", v), 64'(IF_DONE | D_DONE), 64'd0);
            check($sformatf("vec%0d_idle", v), 64'(BUSY), 64'd0);
        end

        // Simultaneous store and fetch: store first, fetch at DONE edge + 2
        do_reset();
        IF_REQ = 1'b1; IF_ADDR = 64'h40;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 64'h100; D_WDATA = 64'hDEAD;
        wait_grant(ok);
        check("both_first_we", 64'(MEM_WE), 64'd1);
        check("both_first_addr", MEM_ADDR, 64'h100);
        check("both_first_wdata", MEM_WDATA, 64'hDEAD);
        serve(2, 1'b0, 64'h0);
        check("both_d_done", 64'(D_DONE), 64'd1);
        check("both_if_not_done", 64'(IF_DONE), 64'd0);
        D_REQ = 1'b0;
        @(posedge CLOCK); #1;
        check("both_gap_no_req", 64'(MEM_REQ), 64'd0);
        check("both_addr_hold", MEM_ADDR, 64'h100);
        @(posedge CLOCK); #1;
        check("both_fetch_req", 64'(MEM_REQ), 64'd1);
        check("both_fetch_addr", MEM_ADDR, 64'h40);
        check("both_fetch_we", 64'(MEM_WE), 64'd0);
        serve(1, 1'b0, 64'h77);
        check("both_if_done", 64'(IF_DONE), 64'd1);
        check("both_if_rdata", IF_RDATA, 64'h77);
        IF_REQ = 1'b0;
        @(posedge CLOCK); #1;

        // Anti-starvation: D D D D IF D
        do_reset();
        IF_REQ = 1'b1; IF_ADDR = 64'h40;
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 64'h100; D_WDATA = 64'h5;
        for (int g = 0; g < 6; g++) begin
            wait_grant(ok);
            got_if = (MEM_ADDR == 64'h40);
            check($sformatf("streak_grant%0d_is_fetch", g), 64'(got_if), 64'(g == 4));
            serve(1, 1'b0, 64'h9);
        end
        IF_REQ = 1'b0; D_REQ = 1'b0;
        @(posedge CLOCK); #1;
        @(posedge CLOCK); #1;

        // Timeout, then stray acks in DONE and IDLE
        do_reset();
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 64'h300;
        wait_grant(ok);
        serve(2, 1'b0, 64'h5555);
        check("to_pre_load", D_RDATA, 64'h5555);
        D_REQ = 1'b0;
        @(posedge CLOCK); #1;
        D_REQ = 1'b1; D_ADDR = 64'h308;
        wait_grant(ok);
        serve(0, 1'b1, 64'h0);
        check("to_d_done", 64'(D_DONE), 64'd1);
        check("to_err", 64'(ERR), 64'd1);
        check("to_d_rdata", D_RDATA, 64'd0);
        check("to_mem_req", 64'(MEM_REQ), 64'd0);
        D_REQ = 1'b0;
        MEM_ACK = 1'b1; MEM_RDATA = 64'h9999;
        @(posedge CLOCK); #1;
        MEM_ACK = 1'b0;
        check("to_done_cleared", 64'({D_DONE, ERR, IF_DONE}), 64'd0);
        check("to_late_ack_data", D_RDATA, 64'd0);
        MEM_ACK = 1'b1;
        @(posedge CLOCK); #1;
        MEM_ACK = 1'b0;
        check("idle_ack_no_done", 64'({D_DONE, IF_DONE}), 64'd0);
        check("idle_ack_data", D_RDATA, 64'd0);
        check("idle_ack_busy", 64'(BUSY), 64'd0);

        // Reset in the middle of a fetch
        IF_REQ = 1'b1; IF_ADDR = 64'h40;
        wait_grant(ok);
        @(posedge CLOCK); #1;
        #2 RESET = 1'b1;
        #1;
        check("midrst_mem_req", 64'(MEM_REQ), 64'd0);
        check("midrst_busy", 64'(BUSY), 64'd0);
        IF_REQ = 1'b0;
        #3 RESET = 1'b0;
        MEM_ACK = 1'b1;
        @(posedge CLOCK); #1;
        MEM_ACK = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("midrst_no_done", 64'(IF_DONE), 64'd0);
            @(posedge CLOCK); #1;
        end
        IF_REQ = 1'b1; IF_ADDR = 64'h48;
        wait_grant(ok);
        check("midrst_new_addr", MEM_ADDR, 64'h48);
        serve(2, 1'b0, 64'hABC);
        check("midrst_new_done", 64'(IF_DONE), 64'd1);
        check("midrst_new_rdata", IF_RDATA, 64'hABC);
        IF_REQ = 1'b0;
        @(posedge CLOCK); #1;

        // Randomized transactions against a transaction-level model
        do_reset();
        streak = 0; m_if_rd = 64'd0; m_d_rd = 64'd0;
        pend_if = 1'b0; pend_d = 1'b0;
        m_if_addr = 64'd0; m_d_addr = 64'd0; m_d_wdata = 64'd0; m_d_we = 1'b0;
        for (int n = 0; n < 250; n++) begin
            if (!pend_if && ($urandom_range(0, 1) == 1)) begin
                pend_if = 1'b1; m_if_addr = rnd64();
            end
            if (!pend_d && ($urandom_range(0, 1) == 1)) begin
                pend_d = 1'b1; m_d_addr = rnd64(); m_d_wdata = rnd64();
                m_d_we = 1'($urandom_range(0, 1));
            end
            if (!pend_if && !pend_d) begin
                pend_if = 1'b1; m_if_addr = rnd64();
            end
            IF_REQ = pend_if; IF_ADDR = m_if_addr;
            D_REQ = pend_d; D_ADDR = m_d_addr; D_WDATA = m_d_wdata; D_WE = m_d_we;
            exp_d = pend_d && !(pend_if && (streak == MAXS));
            wait_grant(ok);
            check("rnd_mem_addr", MEM_ADDR, exp_d ? m_d_addr : m_if_addr);
            check("rnd_mem_we", 64'(MEM_WE), 64'(exp_d && m_d_we));
            if (exp_d && m_d_we) check("rnd_mem_wdata", MEM_WDATA, m_d_wdata);
            if (!exp_d) streak = 0;
            else if (pend_if && streak < MAXS) streak++;
            no_ack = ($urandom_range(0, 9) == 0);
            k = $urandom_range(1, 6);
            rd = rnd64();
            serve(k, no_ack, rd);
            if (no_ack) rd = 64'd0;
            if (exp_d) begin
                if (no_ack || !m_d_we) m_d_rd = rd;
            end else begin
                m_if_rd = rd;
            end
            check("rnd_if_done", 64'(IF_DONE), 64'(!exp_d));
            check("rnd_d_done", 64'(D_DONE), 64'(exp_d));
            check("rnd_err", 64'(ERR), 64'(no_ack));
            check("rnd_if_rdata", IF_RDATA, m_if_rd);
            check("rnd_d_rdata", D_RDATA, m_d_rd);
            if (exp_d) begin
                pend_d = 1'b0; D_REQ = 1'b0;
            end else begin
                pend_if = 1'b0; IF_REQ = 1'b0;
            end
        end
        IF_REQ = 1'b0; D_REQ = 1'b0;
        @(posedge CLOCK); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
